eth_tx_frame_shaper: RTL and testbench

Per-channel TX frame conditioner that sits directly upstream of the 10G Ethernet controller's `tx0_axis_*` port. It zero-pads runt frames up to the minimum MAC payload length and truncates oversize frames at the maximum length, flagging them as errored. It also discards the tail of any truncated frame. Output is registered and honours MAC backpressure at full line rate of 1 beat/clk.

---
 rtl/eth_pkg.sv | 50 +++++
 rtl/eth_axis_skid.sv | 69 ++++++
 rtl/eth_tx_frame_shaper.sv | 210 +++++++++++++++++++++
 tb/tb_eth_tx_frame_shaper.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet TX frame shaper.
// Beat bundle, FSM state and byte-lane mask functions.
package eth_pkg;

    localparam int C_AXIS_DW = 64;
    localparam int C_AXIS_KW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_PAD,
        ST_DROP
    } shaper_state_e;

    typedef struct packed {
        logic [C_AXIS_DW-1:0] data;
        logic [C_AXIS_KW-1:0] keep;
        logic                 last;
        logic                 user;
    } axis_beat_t;

    localparam int C_BEAT_W = $bits(axis_beat_t);

    function automatic logic [3:0] popcount(input logic [C_AXIS_KW-1:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < C_AXIS_KW; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    // n bytes -> contiguous keep mask, saturating at a full beat
    function automatic logic [C_AXIS_KW-1:0] keep_mask(input logic [15:0] n);
        logic [C_AXIS_KW-1:0] m;
        for (int i = 0; i < C_AXIS_KW; i++) begin
            m[i] = (16'(i) < n);
        end
        return m;
    endfunction

    function automatic logic [C_AXIS_DW-1:0] lane_mask(input logic [C_AXIS_KW-1:0] k);
        logic [C_AXIS_DW-1:0] d;
        for (int i = 0; i < C_AXIS_KW; i++) begin
            d[i*8 +: 8] = {8{k[i]}};
        end
        return d;
    endfunction

endpackage

// File: rtl/eth_axis_skid.sv
// Two-entry AXIS register slice with registered output and ready.
// Ready depends only on local state, never on out_ready_i.
module eth_axis_skid
    import eth_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic                in_ready_nxt_o,
    input  logic [C_BEAT_W-1:0] in_beat_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [C_BEAT_W-1:0] out_beat_o
);

    logic                ov_q, ov_d;
    logic                sv_q, sv_d;
    logic                rdy_q;
    logic [C_BEAT_W-1:0] ob_q, ob_d;
    logic [C_BEAT_W-1:0] sb_q, sb_d;
    logic                in_fire;

    assign in_fire = in_valid_i && rdy_q;

    always_comb begin
        ov_d = ov_q;
        sv_d = sv_q;
        ob_d = ob_q;
        sb_d = sb_q;
        if (!ov_q || out_ready_i) begin
            if (sv_q) begin
                ov_d = 1'b1;
                ob_d = sb_q;
                sv_d = 1'b0;
            end else begin
                ov_d = in_fire;
                if (in_fire) begin
                    ob_d = in_beat_i;
                end
            end
        end else if (in_fire) begin
            sv_d = 1'b1;
            sb_d = in_beat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ov_q  <= 1'b0;
            sv_q  <= 1'b0;
            rdy_q <= 1'b0;
            ob_q  <= '0;
            sb_q  <= '0;
        end else begin
            ov_q  <= ov_d;
            sv_q  <= sv_d;
            rdy_q <= !sv_d;
            ob_q  <= ob_d;
            sb_q  <= sb_d;
        end
    end

    assign in_ready_o     = rdy_q;
    assign in_ready_nxt_o = !sv_d;
    assign out_valid_o    = ov_q;
    assign out_beat_o     = ob_q;

endmodule

// File: rtl/eth_tx_frame_shaper.sv
// TX frame conditioner: pads runts, truncates oversize, drops tails.
// Define ETH_TX_SHAPER_STATS_EN to enable the pad/trunc counters.
module eth_tx_frame_shaper
    import eth_pkg::*;
#(
    parameter logic [7:0]  P_MIN_LENGTH = 8'd60,
    parameter logic [14:0] P_MAX_LENGTH = 15'd9600
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    input  logic [C_AXIS_DW-1:0] s_axis_tdata,
    input  logic [C_AXIS_KW-1:0] s_axis_tkeep,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [C_AXIS_DW-1:0] m_axis_tdata,
    output logic [C_AXIS_KW-1:0] m_axis_tkeep,
    output logic [15:0]          o_pad_cnt,
    output logic [15:0]          o_trunc_cnt
);

    shaper_state_e       state_q, state_d;
    logic [14:0]         cnt_q, cnt_d;
    logic                user_q, user_d;
    logic                rdy_q;
    logic                s_fire;
    logic [3:0]          bytes;
    logic [15:0]         sum;
    logic [15:0]         to_min;
    logic [15:0]         to_max;
    logic                is_trunc;
    logic                is_runt;
    logic                min_here;
    logic                push;
    axis_beat_t          beat;
    logic                sk_rdy;
    logic                sk_rdy_nxt;
    logic [C_BEAT_W-1:0] m_beat_w;
    axis_beat_t          m_beat;

    assign s_fire   = s_axis_tvalid && rdy_q;
    assign bytes    = popcount(s_axis_tkeep);
    assign sum      = {1'b0, cnt_q} + 16'(bytes);
    assign to_min   = {8'd0, P_MIN_LENGTH} - {1'b0, cnt_q};
    assign to_max   = {1'b0, P_MAX_LENGTH} - {1'b0, cnt_q};
    assign min_here = (to_min <= 16'd8);
    assign is_runt  = s_axis_tlast && (sum < {8'd0, P_MIN_LENGTH});
    // Hitting the max exactly on a non-last beat ends the frame here
    assign is_trunc = (sum > {1'b0, P_MAX_LENGTH}) ||
                      ((sum == {1'b0, P_MAX_LENGTH}) && !s_axis_tlast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_PASS: begin
                if (s_fire) begin
                    if (is_trunc) begin
                        state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else if (is_runt) begin
                        state_d = min_here ? ST_IDLE : ST_PAD;
                    end else begin
                        state_d = s_axis_tlast ? ST_IDLE : ST_PASS;
                    end
                end
            end
            ST_PAD: begin
                if (sk_rdy && min_here) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (s_fire && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        push   = 1'b0;
        beat   = '0;
        cnt_d  = cnt_q;
        user_d = user_q;
        unique case (state_q)
            ST_IDLE, ST_PASS: begin
                if (s_fire) begin
                    push      = 1'b1;
                    user_d    = user_q | s_axis_tuser;
                    beat.data = s_axis_tdata;
                    beat.keep = s_axis_tkeep;
                    beat.last = s_axis_tlast;
                    beat.user = s_axis_tlast & user_d;
                    cnt_d     = sum[14:0];
                    unique case (1'b1)
                        is_trunc: begin
                            beat.keep = keep_mask(to_max);
                            beat.data = s_axis_tdata & lane_mask(beat.keep);
                            beat.last = 1'b1;
                            beat.user = 1'b1;
                            cnt_d     = '0;
                            user_d    = 1'b0;
                        end
                        is_runt: begin
                            beat.data = s_axis_tdata & lane_mask(s_axis_tkeep);
                            beat.keep = keep_mask(to_min);
                            beat.last = min_here;
                            beat.user = min_here & user_d;
                            cnt_d     = min_here ? '0 : cnt_q + 15'd8;
                            user_d    = min_here ? 1'b0 : user_d;
                        end
                        default: begin
                            if (s_axis_tlast) begin
                                cnt_d  = '0;
                                user_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            ST_PAD: begin
                if (sk_rdy) begin
                    push      = 1'b1;
                    beat.keep = keep_mask(to_min);
                    beat.last = min_here;
                    beat.user = min_here & user_q;
                    cnt_d     = min_here ? '0 : cnt_q + 15'd8;
                    user_d    = min_here ? 1'b0 : user_q;
                end
            end
            ST_DROP: begin
                push = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            user_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            user_q <= user_d;
            rdy_q  <= (state_d == ST_DROP) ||
                      ((state_d != ST_PAD) && sk_rdy_nxt);
        end
    end

    assign s_axis_tready = rdy_q;

    eth_axis_skid u_skid (
        .clk_i          (i_clk),
        .rst_ni         (i_rst_n),
        .in_valid_i     (push),
        .in_ready_o     (sk_rdy),
        .in_ready_nxt_o (sk_rdy_nxt),
        .in_beat_i      (beat),
        .out_valid_o    (m_axis_tvalid),
        .out_ready_i    (m_axis_tready),
        .out_beat_o     (m_beat_w)
    );

    assign m_beat       = axis_beat_t'(m_beat_w);
    assign m_axis_tdata = m_beat.data;
    assign m_axis_tkeep = m_beat.keep;
    assign m_axis_tlast = m_beat.last;
    assign m_axis_tuser = m_beat.user;

`ifdef ETH_TX_SHAPER_STATS_EN
    logic [15:0] pad_cnt_q;
    logic [15:0] trunc_cnt_q;
    logic        pass_fire;

    assign pass_fire = s_fire && ((state_q == ST_IDLE) || (state_q == ST_PASS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pad_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (pass_fire && is_runt && (pad_cnt_q != 16'hFFFF)) begin
                pad_cnt_q <= pad_cnt_q + 16'd1;
            end
            if (pass_fire && is_trunc && (trunc_cnt_q != 16'hFFFF)) begin
                trunc_cnt_q <= trunc_cnt_q + 16'd1;
            end
        end
    end

    assign o_pad_cnt   = pad_cnt_q;
    assign o_trunc_cnt = trunc_cnt_q;
`else
    assign o_pad_cnt   = '0;
    assign o_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_shaper.sv
// Directed bench for eth_tx_frame_shaper: runt, min, oversize,
// back-to-back, random backpressure and reset during padding.
module tb_eth_tx_frame_shaper;
    import eth_pkg::*;

    localparam int MIN_L = 60;
    localparam int MAX_L = 9600;
`ifdef ETH_TX_SHAPER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [15:0] o_pad_cnt;
    logic [15:0] o_trunc_cnt;

    always #5 i_clk = ~i_clk;

    eth_tx_frame_shaper dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .o_pad_cnt     (o_pad_cnt),
        .o_trunc_cnt   (o_trunc_cnt)
    );

    typedef struct {
        int fid;
        int len;
        bit user;
    } frm_t;

    int   n_chk = 0;
    int   n_pass = 0;
    frm_t exp_q[$];
    int   exp_pad = 0;
    int   exp_trunc = 0;
    int   bp_mode = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gen_byte(input int fid, input int i);
        return 8'h80 | 8'((fid * 13 + i) & 127);
    endfunction

    function automatic logic [7:0] mask8(input int n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    always @(posedge i_clk) begin
        #1;
        if (bp_mode == 0) begin
            m_axis_tready = 1'b1;
        end else if (bp_mode == 1) begin
            m_axis_tready = 1'($urandom % 2);
        end else begin
            m_axis_tready = 1'b0;
        end
    end

    logic [7:0]  cur_q[$];
    int          cur_beats = 0;
    int          cyc = 0;
    bit          b2b_on = 1'b0;
    bit          have_last = 1'b0;
    int          last_cyc = 0;
    int          gaps = 0;
    int          stall_viol = 0;
    bit          prev_stall = 1'b0;
    logic [74:0] prev_o = '0;
    logic [74:0] now_o;

    task automatic check_frame(input logic [7:0] lkeep, input logic user);
        frm_t f;
        int   ol;
        int   nerr;
        int   rem;
        logic [7:0] eb;
        if (exp_q.size() == 0) begin
            chk("extra_frame", 1, 0);
            return;
        end
        f = exp_q.pop_front();
        ol = (f.len < MIN_L) ? MIN_L : ((f.len > MAX_L) ? MAX_L : f.len);
        rem = (ol % 8 == 0) ? 8 : ol % 8;
        chk($sformatf("f%0d_len", f.fid), cur_q.size(), ol);
        chk($sformatf("f%0d_beats", f.fid), cur_beats, (ol + 7) / 8);
        chk($sformatf("f%0d_lastkeep", f.fid), lkeep, mask8(rem));
        chk($sformatf("f%0d_user", f.fid), user, (f.len > MAX_L) ? 1 : f.user);
        nerr = 0;
        for (int i = 0; i < cur_q.size() && i < ol; i++) begin
            eb = (i < f.len) ? gen_byte(f.fid, i) : 8'h00;
            if (cur_q[i] !== eb) nerr++;
        end
        chk($sformatf("f%0d_data_errs", f.fid), nerr, 0);
    endtask

    always @(negedge i_clk) begin
        cyc++;
        now_o = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
                 m_axis_tlast, m_axis_tuser};
        if (!i_rst_n) begin
            prev_stall = 1'b0;
            cur_q.delete();
            cur_beats = 0;
        end else begin
            if (prev_stall && (now_o != prev_o)) stall_viol++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_o = now_o;
            if (m_axis_tvalid && m_axis_tready) begin
                if (b2b_on) begin
                    if (have_last && (cyc != last_cyc + 1)) gaps++;
                    have_last = 1'b1;
                    last_cyc = cyc;
                end
                for (int k = 0; k < 8; k++) begin
                    if (m_axis_tkeep[k]) cur_q.push_back(m_axis_tdata[k*8 +: 8]);
                end
                cur_beats++;
                if (m_axis_tlast) begin
                    check_frame(m_axis_tkeep, m_axis_tuser);
                    cur_q.delete();
                    cur_beats = 0;
                end
            end
        end
    end

    task automatic send_frame(input int fid, input int len, input bit u);
        int   nb;
        int   rem;
        int   t;
        bit   acc;
        frm_t f;
        nb = (len == 0) ? 1 : (len + 7) / 8;
        f.fid = fid;
        f.len = len;
        f.user = u;
        exp_q.push_back(f);
        if (len < MIN_L) exp_pad++;
        if (len > MAX_L) exp_trunc++;
        for (int b = 0; b < nb; b++) begin
            rem = len - b * 8;
            for (int k = 0; k < 8; k++) begin
                s_axis_tdata[k*8 +: 8] = (k < rem) ? gen_byte(fid, b * 8 + k) : 8'hEE;
            end
            s_axis_tkeep  = mask8((rem > 8) ? 8 : rem);
            s_axis_tlast  = (b == nb - 1);
            s_axis_tuser  = u && (b == 0);
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            t = 0;
            while (!acc) begin
                @(negedge i_clk);
                acc = s_axis_tready;
                @(posedge i_clk);
                #1;
                t++;
                if (!acc && t > 2000) begin
                    chk("send_timeout", 1, 0);
                    s_axis_tvalid = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        s_axis_tvalid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pad_cnt"}, o_pad_cnt, STATS ? exp_pad : 0);
        chk({tag, "_trunc_cnt"}, o_trunc_cnt, STATS ? exp_trunc : 0);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_m_tuser", m_axis_tuser, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tkeep", m_axis_tkeep, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk_cnts("rst");
        i_rst_n = 1'b1;
        #1;
        chk("rel_s_tready", s_axis_tready, 0);
        @(posedge i_clk);
        #1;
        chk("post_rel_s_tready", s_axis_tready, 1);

        send_frame(1, 20, 1'b0);
        drain();
        chk_cnts("runt");
        send_frame(2, 60, 1'b0);
        drain();
        chk_cnts("min");
        send_frame(3, 0, 1'b1);
        drain();
        chk_cnts("zero");
        send_frame(4, 9610, 1'b0);
        drain();
        chk_cnts("over");

        b2b_on = 1'b1;
        have_last = 1'b0;
        gaps = 0;
        for (int i = 0; i < 3; i++) send_frame(10 + i, 1500, 1'b0);
        drain();
        b2b_on = 1'b0;
        chk("b2b_gaps", gaps, 0);
        chk("b2b_beats_seen", have_last, 1);

        bp_mode = 1;
        for (int i = 0; i < 100; i++) begin
            send_frame(100 + i, (i % 10 == 0) ? 60 : $urandom_range(0, 200),
                       ($urandom % 8) == 0);
        end
        drain();
        bp_mode = 0;
        chk("stall_stable_viol", stall_viol, 0);
        chk_cnts("bp");

        bp_mode = 2;
        send_frame(500, 8, 1'b0);
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("in_pad_state", dut.state_q, ST_PAD);
        i_rst_n = 1'b0;
        exp_q.delete();
        exp_pad = 0;
        exp_trunc = 0;
        #1;
        chk("midpad_rst_tvalid", m_axis_tvalid, 0);
        chk("midpad_rst_state", dut.state_q, ST_IDLE);
        chk("midpad_rst_tready", s_axis_tready, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        bp_mode = 0;
        @(posedge i_clk);
        #1;
        send_frame(501, 100, 1'b0);
        drain();
        chk_cnts("post_rst");
        chk("final_stall_viol", stall_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
